// File: rtl/pipeline_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// It provides the register index type and the arbiter state encoding.
package pipeline_pkg;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} arb_state_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the WB, LL, decode and RegFile write-port signals around the arbiter.
// master = pipeline/LL/RegFile side, slave = the arbiter itself.
interface regfile_wb_arbiter_if
    import pipeline_pkg::*;
#(
    parameter int DW = pipeline_pkg::XLEN
) ();
    logic          wb_we;
    reg_idx_t      wb_rd;
    logic [DW-1:0] wb_wdata;
    logic          ll_valid;
    reg_idx_t      ll_rd;
    logic [DW-1:0] ll_wdata;
    logic          ll_ready;
    logic          ll_issue;
    reg_idx_t      ll_issue_rd;
    reg_idx_t      id_rs1;
    reg_idx_t      id_rs2;
    reg_idx_t      id_rd;
    logic          sb_hazard;
    logic          stall_req;
    logic          rf_we;
    reg_idx_t      rf_waddr;
    logic [DW-1:0] rf_wdata;

    modport master (
        output wb_we, wb_rd, wb_wdata, ll_valid, ll_rd, ll_wdata,
               ll_issue, ll_issue_rd, id_rs1, id_rs2, id_rd,
        input  ll_ready, sb_hazard, stall_req, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_we, wb_rd, wb_wdata, ll_valid, ll_rd, ll_wdata,
               ll_issue, ll_issue_rd, id_rs1, id_rs2, id_rd,
        output ll_ready, sb_hazard, stall_req, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter_reg_scoreboard.sv
// Pending-write scoreboard for long-latency destinations with three lookup ports.
// A set and a clear of the same register in one cycle leaves the bit set.
module reg_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NREG = pipeline_pkg::NREG
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     set_i,
    input  reg_idx_t set_idx_i,
    input  logic     clr_i,
    input  reg_idx_t clr_idx_i,
    input  reg_idx_t q_rs1_i,
    input  reg_idx_t q_rs2_i,
    input  reg_idx_t q_rd_i,
    output logic     hit_rs1_o,
    output logic     hit_rs2_o,
    output logic     hit_rd_o
);
    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_i) begin
            sb_d[clr_idx_i] = 1'b0;
        end
        if (set_i && (set_idx_i != '0)) begin
            sb_d[set_idx_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign hit_rs1_o = (q_rs1_i != '0) && sb_q[q_rs1_i];
    assign hit_rs2_o = (q_rs2_i != '0) && sb_q[q_rs2_i];
    assign hit_rd_o  = (q_rd_i  != '0) && sb_q[q_rd_i];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegFile write port between pipeline WB and the long-latency unit.
// Define WB_STARVE_GUARD_EN to add the starvation counter and forced-grant freeze.
module regfile_wb_arbiter
    import pipeline_pkg::*;
#(
    parameter int XLEN     = pipeline_pkg::XLEN,
    parameter int NREG     = pipeline_pkg::NREG,
    parameter int MAX_WAIT = 4
) (
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave bus
);
    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
        $error("MAX_WAIT must be within 1..15");
    end

    logic            wb_act;
    logic            grant_ll;
    logic            xfer;
    logic            stall_q;
    logic            we_mux;
    reg_idx_t        waddr_mux;
    logic [XLEN-1:0] wdata_mux;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;

`ifdef WB_STARVE_GUARD_EN
    assign wb_act = bus.wb_we;
`else
    // Without the guard, a WB write to x0 is a bubble the LL unit may use.
    assign wb_act = bus.wb_we & (bus.wb_rd != '0);
`endif

    always_comb begin
        grant_ll  = 1'b0;
        we_mux    = 1'b0;
        waddr_mux = bus.wb_rd;
        wdata_mux = bus.wb_wdata;
        if (!rst) begin
            grant_ll = stall_q | (!wb_act & bus.ll_valid);
            if (grant_ll) begin
                waddr_mux = bus.ll_rd;
                wdata_mux = bus.ll_wdata;
                we_mux    = bus.ll_valid & (bus.ll_rd != '0);
            end else begin
                we_mux    = bus.wb_we & (bus.wb_rd != '0);
            end
        end
    end

    assign xfer          = bus.ll_valid & grant_ll;
    assign bus.ll_ready  = grant_ll;
    assign bus.rf_we     = we_mux;
    assign bus.rf_waddr  = waddr_mux;
    assign bus.rf_wdata  = wdata_mux;
    assign bus.stall_req = stall_q;

`ifdef WB_STARVE_GUARD_EN
    arb_state_t state_q;
    logic [3:0] wait_cnt_q;

    // stall_q mirrors state_q == FORCE so the freeze comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ll_valid && !grant_ll) begin
                        wait_cnt_q <= 4'd1;
                        if (MAX_WAIT == 1) begin
                            state_q <= FORCE;
                            stall_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (xfer || !bus.ll_valid) begin
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                        if ((wait_cnt_q + 4'd1) >= 4'(MAX_WAIT)) begin
                            state_q <= FORCE;
                            stall_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    wait_cnt_q <= '0;
                    stall_q    <= 1'b0;
                end
            endcase
        end
    end
`else
    assign stall_q = 1'b0;
`endif

    reg_scoreboard #(
        .NREG(NREG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_i     (bus.ll_issue),
        .set_idx_i (bus.ll_issue_rd),
        .clr_i     (xfer),
        .clr_idx_i (bus.ll_rd),
        .q_rs1_i   (bus.id_rs1),
        .q_rs2_i   (bus.id_rs2),
        .q_rd_i    (bus.id_rd),
        .hit_rs1_o (hit_rs1),
        .hit_rs2_o (hit_rs2),
        .hit_rd_o  (hit_rd)
    );

    assign bus.sb_hazard = hit_rs1 | hit_rs2 | hit_rd;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for the write-port mux,
// hand sequences for scoreboard, starvation and mid-operation reset.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_wdata;
        logic        ll_valid;
        logic [4:0]  ll_rd;
        logic [31:0] ll_wdata;
        logic        e_ready;
        logic        e_we;
        logic        chk_bus;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wb_we       = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_wdata    = '0;
        bus.ll_valid    = 1'b0;
        bus.ll_rd       = '0;
        bus.ll_wdata    = '0;
        bus.ll_issue    = 1'b0;
        bus.ll_issue_rd = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd3,  32'hAA,       1'b1, 5'd7,  32'h77,   1'b0, 1'b1, 1'b1, 5'd3,  32'hAA};
        vecs[1] = '{1'b0, 5'd3,  32'hAA,       1'b1, 5'd7,  32'h1234, 1'b1, 1'b1, 1'b1, 5'd7,  32'h1234};
        vecs[2] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd4,  32'h0,    1'b0, 1'b1, 1'b1, 5'd31, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd2,  32'h1,        1'b0, 5'd4,  32'h2,    1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[4] = '{1'b0, 5'd2,  32'h1,        1'b1, 5'd0,  32'h55,   1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[5] = '{1'b1, 5'd0,  32'h66,       1'b0, 5'd4,  32'h2,    1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
`ifdef WB_STARVE_GUARD_EN
        vecs[6] = '{1'b1, 5'd0,  32'h66,       1'b1, 5'd12, 32'hC,    1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
`else
        vecs[6] = '{1'b1, 5'd0,  32'h66,       1'b1, 5'd12, 32'hC,    1'b1, 1'b1, 1'b1, 5'd12, 32'hC};
`endif

        // Reset state with live requests on the inputs
        rst = 1'b1;
        idle_inputs();
        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd7;
        bus.id_rs1   = 5'd5;
        #2;
        chk("rst_stall", bus.stall_req, 1'b0);
        chk("rst_ready", bus.ll_ready, 1'b0);
        chk("rst_rf_we", bus.rf_we, 1'b0);
        chk("rst_hazard", bus.sb_hazard, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.wb_we    = vecs[i].wb_we;
            bus.wb_rd    = vecs[i].wb_rd;
            bus.wb_wdata = vecs[i].wb_wdata;
            bus.ll_valid = vecs[i].ll_valid;
            bus.ll_rd    = vecs[i].ll_rd;
            bus.ll_wdata = vecs[i].ll_wdata;
            #2;
            chk($sformatf("vec%0d_ready", i), bus.ll_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d_rf_we", i), bus.rf_we, vecs[i].e_we);
            chk($sformatf("vec%0d_stall", i), bus.stall_req, 1'b0);
            if (vecs[i].chk_bus) begin
                chk($sformatf("vec%0d_waddr", i), bus.rf_waddr, vecs[i].e_waddr);
                chk($sformatf("vec%0d_wdata", i), bus.rf_wdata, vecs[i].e_wdata);
            end
            @(negedge clk);
            idle_inputs();
        end

        // Scoreboard: issue to x9, hazard until the LL result for x9 transfers
        @(negedge clk);
        bus.ll_issue    = 1'b1;
        bus.ll_issue_rd = 5'd9;
        bus.id_rs2      = 5'd9;
        #2;
        chk("sb_issue_cycle", bus.sb_hazard, 1'b0);
        @(negedge clk);
        bus.ll_issue = 1'b0;
        #2;
        chk("sb_rs2_hit", bus.sb_hazard, 1'b1);
        bus.id_rs2 = 5'd0;
        bus.id_rd  = 5'd9;
        #1;
        chk("sb_rd_hit", bus.sb_hazard, 1'b1);
        bus.id_rd  = 5'd0;
        bus.id_rs1 = 5'd9;
        #1;
        chk("sb_rs1_hit", bus.sb_hazard, 1'b1);
        @(negedge clk);
        bus.id_rs1   = 5'd0;
        bus.id_rs2   = 5'd9;
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd9;
        bus.ll_wdata = 32'h99;
        #2;
        chk("sb_xfer_ready", bus.ll_ready, 1'b1);
        chk("sb_xfer_waddr", bus.rf_waddr, 5'd9);
        chk("sb_no_bypass", bus.sb_hazard, 1'b1);
        @(negedge clk);
        bus.ll_valid = 1'b0;
        #2;
        chk("sb_cleared", bus.sb_hazard, 1'b0);

        // Set and clear of x9 in the same cycle: set wins
        @(negedge clk);
        bus.ll_issue    = 1'b1;
        bus.ll_issue_rd = 5'd9;
        @(negedge clk);
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd9;
        #2;
        chk("simul_ready", bus.ll_ready, 1'b1);
        @(negedge clk);
        bus.ll_issue = 1'b0;
        bus.ll_valid = 1'b0;
        #2;
        chk("simul_set_wins", bus.sb_hazard, 1'b1);
        @(negedge clk);
        bus.ll_valid = 1'b1;
        #2;
        @(negedge clk);
        bus.ll_valid = 1'b0;
        #2;
        chk("simul_then_clr", bus.sb_hazard, 1'b0);

        // x0 issue never marks a hazard
        @(negedge clk);
        idle_inputs();
        bus.ll_issue    = 1'b1;
        bus.ll_issue_rd = 5'd0;
        @(negedge clk);
        bus.ll_issue = 1'b0;
        #2;
        chk("x0_no_hazard", bus.sb_hazard, 1'b0);

        // LL starved by continuous WB writes
        @(negedge clk);
        idle_inputs();
        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.wb_wdata = 32'hAA;
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd11;
        bus.ll_wdata = 32'hB0B;
        for (int k = 1; k <= 5; k++) begin
            #2;
`ifdef WB_STARVE_GUARD_EN
            chk($sformatf("starve%0d_stall", k), bus.stall_req, (k == 5) ? 1'b1 : 1'b0);
            chk($sformatf("starve%0d_ready", k), bus.ll_ready, (k == 5) ? 1'b1 : 1'b0);
            chk($sformatf("starve%0d_waddr", k), bus.rf_waddr, (k == 5) ? 5'd11 : 5'd3);
`else
            chk($sformatf("starve%0d_stall", k), bus.stall_req, 1'b0);
            chk($sformatf("starve%0d_ready", k), bus.ll_ready, 1'b0);
            chk($sformatf("starve%0d_waddr", k), bus.rf_waddr, 5'd3);
`endif
            @(negedge clk);
        end
`ifdef WB_STARVE_GUARD_EN
        bus.ll_valid = 1'b0;
        #2;
        chk("starve_after_stall", bus.stall_req, 1'b0);
        chk("starve_after_waddr", bus.rf_waddr, 5'd3);
`else
        bus.wb_we = 1'b0;
        #2;
        chk("starve_bubble_ready", bus.ll_ready, 1'b1);
        chk("starve_bubble_waddr", bus.rf_waddr, 5'd11);
`endif

        // Reset in the middle of a forced grant with x5 pending
        @(negedge clk);
        idle_inputs();
        bus.ll_issue    = 1'b1;
        bus.ll_issue_rd = 5'd5;
        @(negedge clk);
        bus.ll_issue = 1'b0;
        bus.id_rs1   = 5'd5;
        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd6;
        repeat (4) @(negedge clk);
        #1;
        chk("mid_hazard_before", bus.sb_hazard, 1'b1);
`ifdef WB_STARVE_GUARD_EN
        chk("mid_stall_before", bus.stall_req, 1'b1);
`endif
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", bus.stall_req, 1'b0);
        chk("mid_rst_hazard", bus.sb_hazard, 1'b0);
        chk("mid_rst_rf_we", bus.rf_we, 1'b0);
        chk("mid_rst_ready", bus.ll_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.wb_we    = 1'b0;
        bus.ll_valid = 1'b0;
        #2;
        chk("post_rst_hazard", bus.sb_hazard, 1'b0);
        chk("post_rst_stall", bus.stall_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
